// File: rtl/poly_phase_acc.sv
// poly_phase_acc: polyphase phase accumulator with handshaked increment loading and a shadow table swap
module poly_phase_acc #(
  parameter int LANES   = 4,
  parameter int PHASE_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [PHASE_W-1:0]       inc_i,
  input  logic                     inc_valid_i,
  output logic                     inc_ready_o,
  input  logic [PHASE_W-1:0]       offset_i,
  input  logic                     phase_clr_i,
  input  logic                     en_i,
  output logic [LANES*PHASE_W-1:0] phase_o,
  output logic                     valid_o,
  output logic                     busy_o
);
  localparam int JW = $clog2(LANES + 1);
  typedef enum logic [1:0] {RUN, CALC, SWAP} state_t;
  state_t state, state_next;
  logic [PHASE_W-1:0] inc, acc, acc_new, base, step, sstep;
  logic [PHASE_W-1:0] off [LANES];
  logic [PHASE_W-1:0] soff [LANES];
  logic [JW-1:0] j;
  assign acc_new = acc + inc;
  assign inc_ready_o = state == RUN;
  assign busy_o = state != RUN;
  always_comb begin
    state_next = state == RUN  ? (inc_valid_i ? CALC : RUN) :
                 state == CALC ? (j == JW'(LANES) ? SWAP : CALC) : RUN;
  end
  always_ff @(posedge clk_i) begin
    state <= rst_i ? RUN : state_next;
  end
  // Shadow tables are built by repeated addition, then copied to the active set in one edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inc   <= '0;
      acc   <= '0;
      j     <= '0;
      sstep <= '0;
      step  <= '0;
      soff  <= '{default: '0};
      off   <= '{default: '0};
    end else if (state == RUN) begin
      if (inc_valid_i) begin
        inc     <= inc_i;
        acc     <= '0;
        j       <= JW'(1);
        soff[0] <= '0;
      end
    end else if (state == CALC) begin
      acc <= acc_new;
      j   <= j + 1'b1;
      for (int k = 1; k < LANES; k++)
        if (j == JW'(k)) soff[k] <= acc_new;
      if (j == JW'(LANES)) sstep <= acc_new;
    end else begin
      off  <= soff;
      step <= sstep;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base    <= '0;
      phase_o <= '0;
      valid_o <= 1'b0;
    end else if (phase_clr_i) begin
      base    <= '0;
      valid_o <= 1'b0;
    end else if (en_i) begin
      for (int k = 0; k < LANES; k++)
        phase_o[k*PHASE_W +: PHASE_W] <= base + off[k] + offset_i;
      base    <= base + step;
      valid_o <= 1'b1;
    end else begin
      valid_o <= 1'b0;
    end
  end
endmodule

// File: doc/poly_phase_acc.md
Name: poly_phase_acc

Overview:
Parametrised polyphase phase accumulator for the parallel NCO/CORDIC/mixer chain. Produces LANES phase words per clock, one for each consecutive sample, to feed LANES cordic instances. Generalises the fixed 4-lane accumulator with the following additions:
- runtime frequency-word loading through a valid/ready handshake, with a glitch-free table swap;
- a static phase offset input;
- a phase clear;
- an enable input.

Parameters:
LANES, 4, number of parallel samples per clock (>=1).
PHASE_W, 32, phase word width; all arithmetic is modulo 2^PHASE_W.

Ports:
clk_i  in  1  clock; all logic is on the rising edge.
rst_i  in  1  synchronous, active-high reset.
inc_i  in  PHASE_W  new per-sample phase increment.
inc_valid_i  in  1  inc_i is valid.
inc_ready_o  out  1  block can accept an increment.
offset_i  in  PHASE_W  phase offset added to every lane output; sampled every enabled cycle.
phase_clr_i  in  1  zero the base accumulator.
en_i  in  1  advance one frame (LANES samples) this cycle.
phase_o  out  LANES*PHASE_W  lane k occupies bits [k*PHASE_W +: PHASE_W]; lane 0 is the oldest sample.
valid_o  out  1  phase_o updated this cycle.
busy_o  out  1  recalculation in progress.

Behaviour:
- State: base[PHASE_W]. Active tables: off[0..LANES-1] and step. Shadow tables: soff[], sstep. Calc accumulator: acc. Lane counter: j.
- Reset: base=0, off[]=0, step=0, shadow tables=0, phase_o=0, valid_o=0, state=RUN, inc_ready_o=1, busy_o=0. Reset applies in any state; an in-progress calc is abandoned and the old tables are not swapped in.
- RUN state:
  - inc_ready_o=1.
  - inc_valid_i & inc_ready_o: latch inc_i, set acc=0, j=1, soff[0]=0, go to CALC.
- CALC state (LANES cycles):
  - inc_ready_o=0, busy_o=1.
  - Each cycle: acc+=inc.
  - If j<LANES: soff[j]=acc_new. If j==LANES: sstep=acc_new, go to SWAP.
  - j increments each cycle.
  - No multipliers: adder chain only.
- SWAP state (1 cycle):
  - off[]<=soff[], step<=sstep, go to RUN.
  - inc_ready_o=0, busy_o=1.
- inc_ready_o is low for exactly LANES+1 cycles after acceptance. The next increment can be accepted on the cycle after SWAP.
- Datapath (independent of the FSM; the active tables are used throughout CALC/SWAP):
  - phase_clr_i=1 (highest priority after reset): base<=0, valid_o<=0, phase_o holds.
  - Else en_i=1: phase_o[k]<=base+off[k]+offset_i, base<=base+step, valid_o<=1.
  - Else: valid_o<=0; phase_o and base hold.
- Latency: 1 cycle from en_i to valid_o/phase_o.
- New tables take effect for the first enabled frame after the SWAP edge. On the SWAP edge itself, the old tables are used.
- Phase continuity: base is never reset by an increment load, so phase is continuous across frequency changes.
- Wrap-around: all sums truncate to PHASE_W bits; no saturation.
- Simultaneous events:
  - clr with SWAP: both take effect.
  - clr with en: clr wins; no output is produced.
  - inc_valid_i while not ready: ignored, and the request must be held by the source.

Test Plan:
- Reset, then en_i=1 with no load -> valid_o rises 1 cycle later; all lanes 0 every frame; inc_ready_o=1.
- LANES=4: load inc 0x15555555, wait 5 cycles, offset 0, en=1 -> frame0 = 0, 0x15555555, 0x2AAAAAAA, 0x3FFFFFFF; frame1 = 0x55555554, 0x6AAAAAA9, 0x7FFFFFFE, 0x95555553. inc_ready_o is low for exactly 5 cycles.
- Load 0x40000000 -> step wraps to 0; every frame = 0, 0x40000000, 0x80000000, 0xC0000000. With offset_i=0x10 -> 0x10, 0x40000010, 0x80000010, 0xC0000010.
- Running with inc A, load B with en=1 continuously -> outputs keep stepping by 4A through CALC/SWAP, then step by 4B from the first frame after SWAP with no phase discontinuity. inc_valid_i held during busy is not accepted twice.
- phase_clr_i pulsed together with en_i -> valid_o=0 the next cycle; the following enabled frame starts at base 0 (lane k = k*inc+offset).
- rst_i asserted mid-CALC -> next cycle inc_ready_o=1, busy_o=0, phase_o=0, and the old increment is discarded (outputs 0 with en=1).
